// File: rtl/snake_stream_pkg.sv
// Shared definitions for the UART command packet path: packet geometry,
// AXI-Stream width, command opcodes and the packer state encoding.
package snake_stream_pkg;

  // Packet geometry: single-beat 64-bit packets built from 8 UART bytes.
  localparam int PKT_BYTES   = 8;
  localparam int BYTE_W      = 8;
  localparam int AXIS_DATA_W = 64;
  localparam int CNT_W       = 3;
  localparam int IDLE_W      = 20;

  // Player command opcodes carried in the first packet byte.
  localparam logic [BYTE_W-1:0] OPC_NOP    = 8'h00;
  localparam logic [BYTE_W-1:0] OPC_MOVE   = 8'h01;
  localparam logic [BYTE_W-1:0] OPC_ACTION = 8'h02;
  localparam logic [BYTE_W-1:0] OPC_PAUSE  = 8'h03;

  // ACCUM: collecting bytes. ACC_FULL: a complete packet waits for the output slot.
  typedef enum logic [0:0] {
    ST_ACCUM    = 1'b0,
    ST_ACC_FULL = 1'b1
  } packer_state_t;

  // Append one byte at the low end; the first byte received ends up in the top byte.
  function automatic logic [AXIS_DATA_W-1:0] shift_in_byte(
    input logic [AXIS_DATA_W-1:0] data,
    input logic [BYTE_W-1:0]      byte_in
  );
    return {data[AXIS_DATA_W-BYTE_W-1:0], byte_in};
  endfunction

endpackage

// File: rtl/packer_byte_accum.sv
// Byte accumulator for the UART packet packer: 64-bit shift register,
// 3-bit byte count and a completion flag raised on the byte that fills it.
module packer_byte_accum
  import snake_stream_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic                   clear,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic [AXIS_DATA_W-1:0] data,
  output logic [CNT_W-1:0]       count,
  output logic                   complete
);

  // The byte being shifted now is the last one of the packet.
  assign complete = shift_en & (count == CNT_W'(PKT_BYTES - 1));

  // Shift a byte in (count wraps 7->0 on the completing byte); a discard clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en) begin
      data  <= shift_in_byte(data, byte_in);
      count <= count + 3'd1;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else begin
      data  <= data;
      count <= count;
    end
  end

endmodule

// File: rtl/uart_packet_packer.sv
// UART packet packer: assembles UART RX bytes into single-beat 64-bit
// AXI-Stream command packets. One output slot plus one accumulator, so the
// next packet can assemble while the current one waits for tready.
// Optional feature: define UART_PACKER_TIMEOUT_EN to discard a partial
// packet after TIMEOUT_CYCLES idle cycles (o_timeout pulses); without it
// o_timeout is 0 and partial packets persist.
module uart_packet_packer
  import snake_stream_pkg::AXIS_DATA_W, snake_stream_pkg::BYTE_W,
         snake_stream_pkg::CNT_W, snake_stream_pkg::IDLE_W,
         snake_stream_pkg::packer_state_t, snake_stream_pkg::ST_ACCUM,
         snake_stream_pkg::ST_ACC_FULL, snake_stream_pkg::shift_in_byte;
#(
  parameter int PKT_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [BYTE_W-1:0]      i_rx_data,
  input  logic                   i_rx_valid,
  output logic [AXIS_DATA_W-1:0] o_m_axis_tdata,
  output logic                   o_m_axis_tvalid,
  output logic                   o_m_axis_tlast,
  input  logic                   i_m_axis_tready,
  output logic                   o_overrun,
  output logic                   o_timeout,
  output logic                   o_busy
);

  // Packet geometry is fixed by the 64-bit stream; the idle counter is 20 bits.
  if (PKT_BYTES != snake_stream_pkg::PKT_BYTES) begin : g_pkt_bytes_check
    $error("uart_packet_packer: PKT_BYTES must be 8");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > ((1 << IDLE_W) - 1))) begin : g_timeout_check
    $error("uart_packet_packer: TIMEOUT_CYCLES out of range for 20-bit counter");
  end

  packer_state_t          state;
  logic [AXIS_DATA_W-1:0] slot_data;
  logic                   slot_valid;
  logic                   overrun_pulse;
  logic                   transfer;
  logic                   acc_shift;
  logic                   acc_clear;
  logic                   acc_complete;
  logic [AXIS_DATA_W-1:0] acc_data;
  logic [CNT_W-1:0]       acc_count;

  assign transfer = slot_valid & i_m_axis_tready;

  // Bytes are accepted while collecting, or in ACC_FULL only when the slot drains this cycle.
  always_comb begin
    acc_shift = 1'b0;
    if (state == ST_ACCUM) begin
      acc_shift = i_rx_valid;
    end else begin
      acc_shift = i_rx_valid & transfer;
    end
  end

  packer_byte_accum u_accum (
    .clk      (i_clk),
    .rst      (i_rst),
    .shift_en (acc_shift),
    .clear    (acc_clear),
    .byte_in  (i_rx_data),
    .data     (acc_data),
    .count    (acc_count),
    .complete (acc_complete)
  );

  // Packer FSM: owns the output slot and the overrun pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_ACCUM;
      slot_data     <= '0;
      slot_valid    <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      overrun_pulse <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (acc_complete) begin
            if (!slot_valid || transfer) begin
              slot_data  <= shift_in_byte(acc_data, i_rx_data);
              slot_valid <= 1'b1;
            end else begin
              state <= ST_ACC_FULL;
            end
          end else if (transfer) begin
            slot_valid <= 1'b0;
          end else begin
            slot_valid <= slot_valid;
          end
        end
        ST_ACC_FULL: begin
          if (transfer) begin
            // Full accumulator replaces the departing beat; any same-cycle byte
            // was already shifted in as byte 0 of the next packet.
            slot_data  <= acc_data;
            slot_valid <= 1'b1;
            state      <= ST_ACCUM;
          end else if (i_rx_valid) begin
            overrun_pulse <= 1'b1;
          end else begin
            state <= ST_ACC_FULL;
          end
        end
        default: begin
          state      <= ST_ACCUM;
          slot_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_PACKER_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;
  logic              timeout_pulse;

  // A partial packet has sat idle long enough; a byte this cycle always wins.
  assign timeout_hit = (state == ST_ACCUM) && (acc_count != '0) && !i_rx_valid &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign acc_clear   = timeout_hit;

  // Idle counter runs only while a partial packet is held; timeout pulse is registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (i_rx_valid || (state != ST_ACCUM) || (acc_count == '0) || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 20'd1;
      end
    end
  end

  assign o_timeout = timeout_pulse;
`else
  assign acc_clear = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_m_axis_tdata  = slot_data;
  assign o_m_axis_tvalid = slot_valid;
  assign o_m_axis_tlast  = slot_valid;
  assign o_overrun       = overrun_pulse;
  assign o_busy          = (acc_count != '0) | (state == ST_ACC_FULL) | slot_valid;

endmodule
